// File: rtl/cpu_pipe_ctrl_pkg.sv
// Shared CPU pipeline types: FSM state encoding and stage-index constants.
package cpu_types;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } pipe_state_e;

  localparam int STAGE_FETCH  = 0;
  localparam int STAGE_DECODE = 1;
  localparam int MIN_STAGES   = 3;
  localparam int MAX_STAGES   = 8;

  // Writeback is always the oldest stage, whatever the configured depth.
  function automatic int stage_wb(input int num_stages);
    return num_stages - 1;
  endfunction

endpackage

// File: rtl/cpu_pipe_ctrl_valid_reg.sv
// Single pipeline-stage valid flop: loads the upstream valid when not held,
// otherwise retains its own valid unless an older redirect squashes it.
module cpu_pipe_valid_reg (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic hold_i,
  input  logic in_valid_i,
  input  logic kill_i,
  output logic valid_o,
  output logic valid_d_o
);

  logic valid_q, valid_d;

  assign valid_d   = hold_i ? (valid_q & ~kill_i) : in_valid_i;
  assign valid_o   = valid_q;
  assign valid_d_o = valid_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) valid_q <= 1'b0;
    else          valid_q <= valid_d;
  end

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// In-order pipeline controller: fetch PC, run/drain/halt FSM, stall/redirect/kill.
// Optional 64-bit cycle/retire counters are built only with CPU_PIPE_PERF_EN defined.
module cpu_pipe_ctrl
  import cpu_types::*;
#(
  parameter int                NUM_STAGES = 5,
  parameter int                XLEN       = 32,
  parameter logic [XLEN-1:0]   RESET_PC   = '0,
  parameter int unsigned       PC_STEP    = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_halt_req,
  input  logic [NUM_STAGES-1:0]      i_stall_req,
  input  logic [NUM_STAGES-1:0]      i_redirect_valid,
  input  logic [NUM_STAGES*XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0]            o_pc,
  output logic                       o_fetch_valid,
  output logic [NUM_STAGES-1:0]      o_stage_en,
  output logic [NUM_STAGES-1:0]      o_stage_valid,
  output logic [NUM_STAGES-1:0]      o_stage_kill,
  output logic [1:0]                 o_state,
  output logic                       o_halted,
  output logic [63:0]                o_cycle_cnt,
  output logic [63:0]                o_retire_cnt
);

  pipe_state_e           state_q, state_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [NUM_STAGES-1:0] raw_valid, hold, kill, valid_eff;
  logic [NUM_STAGES-1:1] next_valid;
  logic [XLEN-1:0]       redir_target;
  logic                  redir_any;
  logic                  drain_done;

  assign raw_valid[STAGE_FETCH] = (state_q == ST_RUN);

  // A stall at any stage also holds every younger stage behind it.
  always_comb begin
    hold = '0;
    for (int k = 0; k < NUM_STAGES; k++) hold[k] = |(i_stall_req >> k);
  end

  // Scan oldest to youngest: the first eligible redirect wins and kills all younger stages.
  always_comb begin
    redir_any    = 1'b0;
    redir_target = pc_q;
    kill         = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      kill[k] = redir_any;
      if (!redir_any && i_redirect_valid[k] && raw_valid[k] && !hold[k]) begin
        redir_any    = 1'b1;
        redir_target = i_redirect_pc[k*XLEN +: XLEN];
      end
    end
  end

  assign valid_eff = raw_valid & ~kill;

  for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stage
    cpu_pipe_valid_reg u_valid_reg (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .hold_i     (hold[k]),
      .in_valid_i (valid_eff[k-1] & ~hold[k-1]),
      .kill_i     (kill[k]),
      .valid_o    (raw_valid[k]),
      .valid_d_o  (next_valid[k])
    );
  end

  // Drain completes when the pipe will be empty from the next cycle on.
  assign drain_done = ~|next_valid;

  always_comb begin
    if (redir_any)                          pc_d = redir_target;
    else if (hold[0] || state_q != ST_RUN)  pc_d = pc_q;
    else                                    pc_d = pc_q + XLEN'(PC_STEP);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_start)    state_d = ST_RUN;
      ST_RUN:    if (i_halt_req) state_d = ST_DRAIN;
      ST_DRAIN:  if (drain_done) state_d = ST_HALTED;
      ST_HALTED: if (i_start)    state_d = ST_RUN;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_fetch_valid = raw_valid[STAGE_FETCH];
  assign o_stage_en    = ~hold;
  assign o_stage_valid = valid_eff;
  assign o_stage_kill  = kill;
  assign o_state       = state_q;
  assign o_halted      = (state_q == ST_HALTED);

`ifdef CPU_PIPE_PERF_EN
  logic [63:0] cycle_cnt_q, retire_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (state_q != ST_IDLE) cycle_cnt_q <= cycle_cnt_q + 64'd1;
      if (valid_eff[stage_wb(NUM_STAGES)] && !hold[stage_wb(NUM_STAGES)])
        retire_cnt_q <= retire_cnt_q + 64'd1;
    end
  end

  assign o_cycle_cnt  = cycle_cnt_q;
  assign o_retire_cnt = retire_cnt_q;
`else
  assign o_cycle_cnt  = '0;
  assign o_retire_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Self-checking bench for cpu_pipe_ctrl: directed scenarios plus randomized
// stimulus against a slot-array reference model of the pipeline.
module tb_cpu_pipe_ctrl;

  localparam int N    = 5;
  localparam int XLEN = 32;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_DRAIN = 2, ST_HALTED = 3;
`ifdef CPU_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic              i_halt_req = 1'b0;
  logic [N-1:0]      i_stall_req = '0;
  logic [N-1:0]      i_redirect_valid = '0;
  logic [N*XLEN-1:0] i_redirect_pc = '0;
  logic [XLEN-1:0]   o_pc;
  logic              o_fetch_valid;
  logic [N-1:0]      o_stage_en, o_stage_valid, o_stage_kill;
  logic [1:0]        o_state;
  logic              o_halted;
  logic [63:0]       o_cycle_cnt, o_retire_cnt;

  cpu_pipe_ctrl #(.NUM_STAGES(N), .XLEN(XLEN), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_halt_req(i_halt_req),
    .i_stall_req(i_stall_req), .i_redirect_valid(i_redirect_valid),
    .i_redirect_pc(i_redirect_pc), .o_pc(o_pc), .o_fetch_valid(o_fetch_valid),
    .o_stage_en(o_stage_en), .o_stage_valid(o_stage_valid), .o_stage_kill(o_stage_kill),
    .o_state(o_state), .o_halted(o_halted), .o_cycle_cnt(o_cycle_cnt),
    .o_retire_cnt(o_retire_cnt)
  );

  always #5 i_clk = ~i_clk;

  int test_cnt = 0;
  int fail_cnt = 0;

  // Reference model: one occupancy bit per pipeline slot plus PC, mode and counters.
  int              m_state;
  bit              m_v[N];
  logic [XLEN-1:0] m_pc;
  longint unsigned m_cyc, m_ret;
  bit              e_hold[N];
  int              e_acc;
  logic [N-1:0]    exp_valid, exp_en, exp_kill;

  function automatic void model_reset();
    m_state = ST_IDLE;
    m_pc    = 32'h0;
    m_cyc   = 0;
    m_ret   = 0;
    for (int k = 0; k < N; k++) m_v[k] = 1'b0;
  endfunction

  function automatic void model_eval();
    bit raw[N];
    e_acc = -1;
    for (int k = 0; k < N; k++) begin
      raw[k]    = (k == 0) ? (m_state == ST_RUN) : m_v[k];
      e_hold[k] = 1'b0;
      for (int j = k; j < N; j++) if (i_stall_req[j]) e_hold[k] = 1'b1;
    end
    for (int j = N - 1; j >= 0; j--)
      if (e_acc < 0 && i_redirect_valid[j] && raw[j] && !e_hold[j]) e_acc = j;
    for (int k = 0; k < N; k++) begin
      exp_kill[k]  = (e_acc > k);
      exp_valid[k] = raw[k] && !exp_kill[k];
      exp_en[k]    = !e_hold[k];
    end
  endfunction

  function automatic void model_advance();
    bit nv[N];
    bit empty;
    if (!i_rst_n) begin
      model_reset();
      return;
    end
    model_eval();
    if (m_state != ST_IDLE) m_cyc++;
    if (exp_valid[N-1] && !e_hold[N-1]) m_ret++;
    if (e_acc >= 0) m_pc = i_redirect_pc[e_acc*XLEN +: XLEN];
    else if (m_state == ST_RUN && !e_hold[0]) m_pc = m_pc + 32'd4;
    empty = 1'b1;
    nv[0] = 1'b0;
    for (int k = 1; k < N; k++) begin
      nv[k] = e_hold[k] ? exp_valid[k] : (exp_valid[k-1] && !e_hold[k-1]);
      if (nv[k]) empty = 1'b0;
    end
    for (int k = 0; k < N; k++) m_v[k] = nv[k];
    case (m_state)
      ST_IDLE:   if (i_start)    m_state = ST_RUN;
      ST_RUN:    if (i_halt_req) m_state = ST_DRAIN;
      ST_DRAIN:  if (empty)      m_state = ST_HALTED;
      default:   if (i_start)    m_state = ST_RUN;
    endcase
  endfunction

  task automatic settle();
    #1;
    if (!i_rst_n) model_reset();
    model_eval();
  endtask

  task automatic cyc();
    @(posedge i_clk);
    model_advance();
    #2;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    #2;
    settle();
    test_cnt++; if (o_state !== 2'd0) begin fail_cnt++; $display("FAIL reset_state got %0d want 0", o_state); end
    test_cnt++; if (o_pc !== 32'h0) begin fail_cnt++; $display("FAIL reset_pc got %h want 0", o_pc); end
    test_cnt++; if (o_stage_valid !== 5'b0) begin fail_cnt++; $display("FAIL reset_valid got %b want 00000", o_stage_valid); end
    test_cnt++; if (o_stage_en !== 5'b11111) begin fail_cnt++; $display("FAIL reset_en got %b want 11111", o_stage_en); end
    test_cnt++; if (o_stage_kill !== 5'b0) begin fail_cnt++; $display("FAIL reset_kill got %b want 00000", o_stage_kill); end
    test_cnt++; if (o_fetch_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_fetch got %b want 0", o_fetch_valid); end
    test_cnt++; if (o_cycle_cnt !== 64'd0 || o_retire_cnt !== 64'd0) begin
      fail_cnt++; $display("FAIL reset_cnt got %0d/%0d want 0/0", o_cycle_cnt, o_retire_cnt); end
    cyc();
    i_rst_n = 1'b1;
    settle();
  endtask

  task automatic test_fill();
    logic [N-1:0]    fill_v [5] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
    logic [XLEN-1:0] fill_pc[4] = '{32'd0, 32'd4, 32'd8, 32'd12};
    i_start = 1'b1;
    settle();
    cyc();
    i_start = 1'b0;
    settle();
    for (int i = 0; i < 5; i++) begin
      test_cnt++; if (o_stage_valid !== fill_v[i]) begin
        fail_cnt++; $display("FAIL fill_valid[%0d] got %b want %b", i, o_stage_valid, fill_v[i]); end
      if (i < 4) begin
        test_cnt++; if (o_pc !== fill_pc[i]) begin
          fail_cnt++; $display("FAIL fill_pc[%0d] got %h want %h", i, o_pc, fill_pc[i]); end
      end
      cyc();
      settle();
    end
  endtask

  task automatic test_stall();
    logic [XLEN-1:0] frozen;
    frozen = m_pc;
    i_stall_req = 5'b00100;
    for (int r = 0; r < 2; r++) begin
      settle();
      test_cnt++; if (o_stage_en !== 5'b11000) begin
        fail_cnt++; $display("FAIL stall_en[%0d] got %b want 11000", r, o_stage_en); end
      test_cnt++; if (o_pc !== frozen) begin
        fail_cnt++; $display("FAIL stall_pc[%0d] got %h want %h", r, o_pc, frozen); end
      cyc();
      settle();
      test_cnt++; if (o_stage_valid[3] !== 1'b0) begin
        fail_cnt++; $display("FAIL stall_bubble[%0d] got %b want 0", r, o_stage_valid[3]); end
    end
    i_stall_req = '0;
    settle();
  endtask

  task automatic test_redirect();
    run_cycles(5);
    i_redirect_valid = 5'b01010;
    i_redirect_pc[3*XLEN +: XLEN] = 32'h100;
    i_redirect_pc[1*XLEN +: XLEN] = 32'h200;
    settle();
    test_cnt++; if (o_stage_kill !== 5'b00111) begin
      fail_cnt++; $display("FAIL redir_kill got %b want 00111", o_stage_kill); end
    test_cnt++; if (o_stage_valid !== 5'b11000) begin
      fail_cnt++; $display("FAIL redir_valid got %b want 11000", o_stage_valid); end
    cyc();
    i_redirect_valid = '0;
    settle();
    test_cnt++; if (o_pc !== 32'h100) begin
      fail_cnt++; $display("FAIL redir_pc got %h want 00000100", o_pc); end
    test_cnt++; if (o_stage_valid !== 5'b10001) begin
      fail_cnt++; $display("FAIL redir_after_valid got %b want 10001", o_stage_valid); end
  endtask

  task automatic test_halt();
    logic [XLEN-1:0] halt_pc;
    int n;
    run_cycles(5);
    i_halt_req = 1'b1;
    settle();
    halt_pc = m_pc + 32'd4;
    cyc();
    i_halt_req = 1'b0;
    settle();
    n = 0;
    while (o_state == 2'd2 && n < 20) begin
      n++;
      cyc();
      settle();
    end
    test_cnt++; if (n !== 4) begin fail_cnt++; $display("FAIL drain_cycles got %0d want 4", n); end
    test_cnt++; if (o_state !== 2'd3 || o_halted !== 1'b1) begin
      fail_cnt++; $display("FAIL halted got state %0d halted %b want 3/1", o_state, o_halted); end
    run_cycles(3);
    settle();
    test_cnt++; if (o_pc !== halt_pc) begin fail_cnt++; $display("FAIL halt_pc got %h want %h", o_pc, halt_pc); end
    i_start = 1'b1;
    settle();
    cyc();
    i_start = 1'b0;
    settle();
    test_cnt++; if (o_state !== 2'd1 || o_pc !== halt_pc) begin
      fail_cnt++; $display("FAIL resume got state %0d pc %h want 1/%h", o_state, o_pc, halt_pc); end
    cyc();
    settle();
    test_cnt++; if (o_pc !== halt_pc + 32'd4) begin
      fail_cnt++; $display("FAIL resume_step got %h want %h", o_pc, halt_pc + 32'd4); end
  endtask

  task automatic test_midrun_reset();
    run_cycles(2);
    i_rst_n = 1'b0;
    settle();
    test_cnt++; if (o_state !== 2'd0 || o_pc !== 32'h0 || o_stage_valid !== 5'b0) begin
      fail_cnt++; $display("FAIL midrun_reset got state %0d pc %h valid %b want 0/0/00000", o_state, o_pc, o_stage_valid); end
    cyc();
    i_rst_n = 1'b1;
    settle();
  endtask

  task automatic test_perf();
    longint unsigned want_cyc, want_ret;
    want_cyc = PERF ? 64'd10 : 64'd0;
    want_ret = PERF ? 64'd6 : 64'd0;
    i_start = 1'b1;
    settle();
    cyc();
    i_start = 1'b0;
    run_cycles(10);
    settle();
    test_cnt++; if (o_cycle_cnt !== want_cyc) begin
      fail_cnt++; $display("FAIL perf_cycles got %0d want %0d", o_cycle_cnt, want_cyc); end
    test_cnt++; if (o_retire_cnt !== want_ret) begin
      fail_cnt++; $display("FAIL perf_retire got %0d want %0d", o_retire_cnt, want_ret); end
  endtask

  task automatic test_random();
    logic [63:0] want_cyc, want_ret;
    for (int c = 0; c < 3000; c++) begin
      bit rst_now;
      rst_now    = ($urandom_range(0, 299) == 0);
      i_rst_n    = !rst_now;
      i_start    = ($urandom_range(0, 9) == 0);
      i_halt_req = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < N; k++) begin
        i_stall_req[k]      = !rst_now && ($urandom_range(0, 7) == 0);
        i_redirect_valid[k] = ($urandom_range(0, 9) == 0);
        i_redirect_pc[k*XLEN +: XLEN] = $urandom & 32'hFFFF_FFFC;
      end
      settle();
      want_cyc = PERF ? m_cyc : 64'd0;
      want_ret = PERF ? m_ret : 64'd0;
      test_cnt++; if (o_pc !== m_pc) begin
        fail_cnt++; $display("FAIL rnd_pc c%0d got %h want %h", c, o_pc, m_pc); end
      test_cnt++; if (o_state !== 2'(m_state) || o_halted !== (m_state == ST_HALTED)) begin
        fail_cnt++; $display("FAIL rnd_state c%0d got %0d/%b want %0d", c, o_state, o_halted, m_state); end
      test_cnt++; if (o_fetch_valid !== (m_state == ST_RUN)) begin
        fail_cnt++; $display("FAIL rnd_fetch c%0d got %b", c, o_fetch_valid); end
      test_cnt++; if (o_stage_en !== exp_en) begin
        fail_cnt++; $display("FAIL rnd_en c%0d got %b want %b", c, o_stage_en, exp_en); end
      test_cnt++; if (o_stage_valid !== exp_valid) begin
        fail_cnt++; $display("FAIL rnd_valid c%0d got %b want %b", c, o_stage_valid, exp_valid); end
      test_cnt++; if (o_stage_kill !== exp_kill) begin
        fail_cnt++; $display("FAIL rnd_kill c%0d got %b want %b", c, o_stage_kill, exp_kill); end
      test_cnt++; if (o_cycle_cnt !== want_cyc || o_retire_cnt !== want_ret) begin
        fail_cnt++; $display("FAIL rnd_cnt c%0d got %0d/%0d want %0d/%0d", c, o_cycle_cnt, o_retire_cnt, want_cyc, want_ret); end
      cyc();
    end
    i_rst_n = 1'b1;
    i_start = 1'b0;
    i_halt_req = 1'b0;
    i_stall_req = '0;
    i_redirect_valid = '0;
    settle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_stall();
    test_redirect();
    test_halt();
    test_midrun_reset();
    test_perf();
    test_random();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/cpu_pipe_ctrl.md
CPU_PIPE_CTRL -- requirements
Module: cpu_pipe_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 5, meaning pipeline depth including fetch (legal 3..8).
REQ-002 The block SHALL have parameter XLEN, default 32, meaning PC width.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0, meaning the PC loaded at reset.
REQ-004 The block SHALL have parameter PC_STEP, default 4, meaning the sequential PC increment.
REQ-005 i_clk  in  1  clock; i_rst_n  in  1  reset, asynchronous, active-low; all state SHALL be on i_clk rising edge.
REQ-006 i_start  in  1  leave IDLE/HALTED and begin fetching.
REQ-007 i_halt_req  in  1  stop fetch and drain the pipeline.
REQ-008 i_stall_req  in  NUM_STAGES  per-stage hold request; bit k = stage k (0 = fetch, NUM_STAGES-1 = writeback).
REQ-009 i_redirect_valid  in  NUM_STAGES  per-stage control-flow redirect request.
REQ-010 i_redirect_pc  in  NUM_STAGES*XLEN  redirect targets, slice k for stage k.
REQ-011 o_pc  out  XLEN  current fetch PC, registered.
REQ-012 o_fetch_valid  out  1  fetch at o_pc is live this cycle.
REQ-013 o_stage_en  out  NUM_STAGES  load enable: bit 0 = PC register, bit k = pipeline register feeding stage k.
REQ-014 o_stage_valid  out  NUM_STAGES  effective valid per stage after kill.
REQ-015 o_stage_kill  out  NUM_STAGES  stage squashed this cycle by an older redirect.
REQ-016 o_state  out  2  FSM state; o_halted  out  1  state==HALTED.
REQ-017 o_cycle_cnt, o_retire_cnt  out  64 each  performance counters (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN, HALTED, encoded 0..3.
REQ-019 Transitions SHALL be: IDLE -i_start-> RUN; RUN -i_halt_req-> DRAIN; DRAIN -all raw valids of stages 1..N-1 zero-> HALTED; HALTED -i_start-> RUN; i_halt_req takes priority over i_start in RUN.
REQ-020 o_fetch_valid SHALL equal (state==RUN) combinationally.
REQ-021 hold[k] SHALL equal OR of i_stall_req[j] for j>=k (a stalled stage holds all younger stages).
REQ-022 kill[k] SHALL equal OR of accepted redirects at j>k; a redirect at stage j is accepted only when raw valid[j]=1, hold[j]=0 and no older redirect is accepted.
REQ-023 o_stage_valid[k] SHALL equal raw valid[k] AND NOT kill[k]; stage 0 raw valid is o_fetch_valid.
REQ-024 o_stage_en[k] SHALL equal NOT hold[k]; pipeline register k SHALL load valid_eff[k-1] when enabled, else retain raw valid[k] AND NOT kill[k].
REQ-025 A bubble (raw valid[k]<=0) SHALL be inserted when hold[k-1]=1 and hold[k]=0.
REQ-026 PC next value SHALL be, in priority: accepted redirect PC of the oldest redirecting stage (even in DRAIN/HALTED); hold o_pc if hold[0] or state!=RUN; else o_pc+PC_STEP, modulo 2^XLEN.
REQ-027 A redirect overrides a stall of younger stages in the same cycle; the redirecting stage itself is not killed.
REQ-028 Simultaneous redirects: only the highest-index accepted redirect SHALL take effect; younger ones are killed.
REQ-029 Latency: redirect in cycle t SHALL present the target on o_pc in cycle t+1 with o_stage_valid[1..k] killed/bubbled.

Reset
REQ-030 On i_rst_n low: state=IDLE, o_pc=RESET_PC, all raw valids 0, counters 0; o_stage_en all ones, o_stage_valid/o_stage_kill zero.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight state immediately with no drain.

Configuration
REQ-032 With macro CPU_PIPE_PERF_EN defined, o_cycle_cnt SHALL increment every cycle state!=IDLE and o_retire_cnt SHALL increment when o_stage_valid[N-1]=1 and hold[N-1]=0, both wrapping at 2^64.
REQ-033 Without CPU_PIPE_PERF_EN, both counter outputs SHALL be constant 0 and no counter flops synthesised.

Structure
REQ-034 The FSM state enum and stage-index constants SHALL live in the shared cpu_types package.
REQ-035 One sub-module, cpu_pipe_valid_reg (single-stage valid/hold/kill flop), SHALL be instantiated per stage via generate.

Verification
REQ-036 Reset then i_start: o_pc sequence 0,4,8,12; o_stage_valid fills 1,3,7,15,31 over five cycles.
REQ-037 i_stall_req[2]=1 for 2 cycles at steady state: o_stage_en=5'b11000, o_pc frozen, raw valid[3]=0 bubble each cycle.
REQ-038 i_redirect_valid[3] with target 0x100 and simultaneous i_redirect_valid[1] with 0x200: o_pc=0x100 next cycle, o_stage_kill=5'b00111.
REQ-039 i_halt_req in RUN with full pipe: DRAIN for 4 cycles, then HALTED, o_pc static; i_start resumes from that PC.
REQ-040 CPU_PIPE_PERF_EN build: 10 RUN cycles, no stalls: o_cycle_cnt=10, o_retire_cnt=6; non-perf build: both 0.
